// File: rtl/fios_mm_seq_if.sv
// Operand-load / start / result-read bus of fios_mm_seq.
// The master drives operands and start; the slave (multiplier) returns status and result words.
interface fios_mm_seq_if #(
   parameter int W = 17,
   parameter int S = 8
);
   localparam int AW = $clog2(S + 1);

   logic          start_i;
   logic          busy_o;
   logic          done_o;
   logic          wr_en_i;
   logic [1:0]    wr_sel_i;
   logic [AW-1:0] wr_addr_i;
   logic [W-1:0]  wr_data_i;
   logic [W-1:0]  p_prime_0_i;
   logic [AW-1:0] rd_addr_i;
   logic [W-1:0]  rd_data_o;

   modport master (
      output start_i, wr_en_i, wr_sel_i, wr_addr_i, wr_data_i, p_prime_0_i, rd_addr_i,
      input  busy_o, done_o, rd_data_o
   );

   modport slave (
      input  start_i, wr_en_i, wr_sel_i, wr_addr_i, wr_data_i, p_prime_0_i, rd_addr_i,
      output busy_o, done_o, rd_data_o
   );
endinterface

// File: rtl/fios_mm_seq.sv
// Word-serial Montgomery FIOS multiplier: a*b*R^-1 mod p with R = 2^(W*S), one word per cycle.
// Define FIOS_MM_FINAL_SUB_EN to add the final conditional subtraction (result < p instead of < 2p).
module fios_mm_seq #(
   parameter int W = 17,
   parameter int S = 8
) (
   input  logic         clock_i,
   input  logic         reset_i,
   fios_mm_seq_if.slave bus
);
   localparam int AW = $clog2(S + 1);
   localparam int IW = (S > 1) ? $clog2(S) : 1;
   localparam int CW = W + 2;
   localparam int UW = 2 * W + 2;
   localparam logic [AW-1:0] S_A    = AW'(S);
   localparam logic [AW-1:0] LAST_A = AW'(S - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MCOMP,
      ST_INNER,
      ST_TOP,
      ST_DONE
`ifdef FIOS_MM_FINAL_SUB_EN
      , ST_SUB
`endif
   } state_t;

   state_t        r_state;
   logic          r_busy;
   logic          r_done;
   logic [AW-1:0] r_i;
   logic [AW-1:0] r_j;
   logic [CW-1:0] r_c;
   logic [W-1:0]  r_m;
   logic [W-1:0]  r_pp;
   logic [W-1:0]  r_rd;
   logic [W-1:0]  r_t [S+1];
   logic [W-1:0]  r_a [S];
   logic [W-1:0]  r_b [S];
   logic [W-1:0]  r_p [S];

   logic          w_wr_ok;
   logic [IW-1:0] w_wr_idx;
   logic [IW-1:0] w_i_idx;
   logic [IW-1:0] w_j_idx;
   logic [W-1:0]  w_aj;
   logic [W-1:0]  w_bi;
   logic [W-1:0]  w_pj;
   logic [W-1:0]  w_tj;
   logic [W-1:0]  w_m;
   logic [UW-1:0] w_mp;
   logic [UW-1:0] w_cin;
   logic [UW-1:0] w_u;
   logic [W:0]    w_top;

   // Operand writes only land while the sequencer is idle; addresses >= S and select 3 are dropped.
   assign w_wr_ok  = bus.wr_en_i && (r_state == ST_IDLE) && (bus.wr_addr_i < S_A);
   assign w_wr_idx = bus.wr_addr_i[IW-1:0];

   // NOTE: operand storage has no reset so it maps onto plain RAM; contents survive a reset on purpose.
   always_ff @(posedge clock_i) begin
      if (w_wr_ok) begin
         case (bus.wr_sel_i)
            2'd0:    r_a[w_wr_idx] <= bus.wr_data_i;
            2'd1:    r_b[w_wr_idx] <= bus.wr_data_i;
            2'd2:    r_p[w_wr_idx] <= bus.wr_data_i;
            default: ;
         endcase
      end
   end

   assign w_i_idx = r_i[IW-1:0];
   assign w_j_idx = r_j[IW-1:0];
   assign w_aj    = r_a[w_j_idx];
   assign w_bi    = r_b[w_i_idx];
   assign w_pj    = r_p[w_j_idx];
   assign w_tj    = r_t[r_j];

   // NOTE: every always_comb output is given a default first so no path can infer a latch.
   always_comb begin
      w_mp  = '0;
      w_cin = '0;
      if (r_state == ST_INNER) begin
         w_mp  = UW'(r_m) * UW'(w_pj);
         w_cin = UW'(r_c);
      end
   end

   // One MAC serves both MCOMP (j is 0, m and carry terms gated off) and INNER.
   assign w_u   = UW'(w_tj) + UW'(w_aj) * UW'(w_bi) + w_mp + w_cin;
   assign w_m   = w_u[W-1:0] * r_pp;
   assign w_top = (W + 1)'(r_t[S]) + (W + 1)'(r_c);

`ifdef FIOS_MM_FINAL_SUB_EN
   logic          r_borrow;
   logic          r_flag;
   logic [W-1:0]  r_d [S+1];
   logic [W-1:0]  w_pk;
   logic [W:0]    w_diff;

   // d = t - p over S+1 words; p has no word S.
   assign w_pk   = (r_j < S_A) ? w_pj : '0;
   assign w_diff = {1'b0, w_tj} - {1'b0, w_pk} - {{W{1'b0}}, r_borrow};

   always_ff @(posedge clock_i) begin
      if (r_state == ST_SUB) r_d[r_j] <= w_diff[W-1:0];
   end
`endif

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_i     <= '0;
         r_j     <= '0;
         r_c     <= '0;
         r_m     <= '0;
         r_pp    <= '0;
         for (int k = 0; k <= S; k++) r_t[k] <= '0;
`ifdef FIOS_MM_FINAL_SUB_EN
         r_borrow <= 1'b0;
         r_flag   <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_busy <= 1'b0;
               if (bus.start_i) begin
                  for (int k = 0; k <= S; k++) r_t[k] <= '0;
                  r_i     <= '0;
                  r_j     <= '0;
                  r_c     <= '0;
                  r_pp    <= bus.p_prime_0_i;
`ifdef FIOS_MM_FINAL_SUB_EN
                  r_flag  <= 1'b0;
`endif
                  r_state <= ST_MCOMP;
               end
            end
            ST_MCOMP: begin
               r_busy  <= 1'b1;
               r_m     <= w_m;
               r_j     <= '0;
               r_c     <= '0;
               r_state <= ST_INNER;
            end
            ST_INNER: begin
               r_busy <= 1'b1;
               if (r_j != '0) r_t[r_j - 1'b1] <= w_u[W-1:0];
               r_c <= w_u[W +: CW];
               if (r_j == LAST_A) begin
                  r_j     <= '0;
                  r_state <= ST_TOP;
               end else begin
                  r_j <= r_j + 1'b1;
               end
            end
            ST_TOP: begin
               r_busy   <= 1'b1;
               r_t[S-1] <= w_top[W-1:0];
               r_t[S]   <= {{(W - 1){1'b0}}, w_top[W]};
               r_i      <= r_i + 1'b1;
               if (r_i == LAST_A) begin
`ifdef FIOS_MM_FINAL_SUB_EN
                  r_borrow <= 1'b0;
                  r_state  <= ST_SUB;
`else
                  r_state  <= ST_DONE;
`endif
               end else begin
                  r_state <= ST_MCOMP;
               end
            end
`ifdef FIOS_MM_FINAL_SUB_EN
            ST_SUB: begin
               r_busy   <= 1'b1;
               r_borrow <= w_diff[W];
               if (r_j == S_A) begin
                  r_flag  <= ~w_diff[W];
                  r_state <= ST_DONE;
               end else begin
                  r_j <= r_j + 1'b1;
               end
            end
`endif
            ST_DONE: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         r_rd <= '0;
      end else if (bus.rd_addr_i < S_A) begin
`ifdef FIOS_MM_FINAL_SUB_EN
         r_rd <= r_flag ? r_d[bus.rd_addr_i] : r_t[bus.rd_addr_i];
`else
         r_rd <= r_t[bus.rd_addr_i];
`endif
      end else begin
         r_rd <= '0;
      end
   end

   assign bus.busy_o    = r_busy;
   assign bus.done_o    = r_done;
   assign bus.rd_data_o = r_rd;
endmodule

// File: tb/tb_fios_mm_seq.sv
// Scoreboard bench for fios_mm_seq at W=4, S=2: stimulus pushes expected results,
// a monitor pops and compares them on every done_o pulse.
`timescale 1ns/1ps
module tb_fios_mm_seq;
   localparam int W  = 4;
   localparam int S  = 2;
   localparam int AW = $clog2(S + 1);
`ifdef FIOS_MM_FINAL_SUB_EN
   localparam int P  = 'hB3;   // R = 256, R mod p = 0x4D, R^-1 mod p = 93
   localparam int PP = 5;
   localparam int R2 = 'h16;
   localparam int RM = 'h4D;
   localparam int L  = 12;
`else
   localparam int P  = 'h35;   // R = 256, R mod p = 0x2C, R^-1 mod p = 47
   localparam int PP = 3;
   localparam int R2 = 'h1C;
   localparam int RM = 'h2C;
   localparam int L  = 9;
`endif

   typedef struct { int a; int b; int e; } vec_t;
   typedef struct { int e; int acc; } item_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   int    cyc = 0;
   int    n_vec = 0;
   int    n_err = 0;
   int    n_seen = 0;
   int    busy_cnt = 0;
   item_t sb_q[$];
   vec_t  vecs[5];

   fios_mm_seq_if #(.W(W), .S(S)) bus ();

   fios_mm_seq #(.W(W), .S(S)) dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic wr(input int sel, input int addr, input int data);
      bus.wr_en_i   = 1'b1;
      bus.wr_sel_i  = 2'(sel);
      bus.wr_addr_i = AW'(addr);
      bus.wr_data_i = W'(data);
      @(negedge clk);
      bus.wr_en_i   = 1'b0;
   endtask

   task automatic load(input int a, input int b);
      for (int k = 0; k < S; k++) begin
         wr(0, k, a >> (k * W));
         wr(1, k, b >> (k * W));
         wr(2, k, P >> (k * W));
      end
      wr(0, S, 'hF);   // out-of-range address, must be dropped
      wr(3, 0, 'hF);   // select 3, must be dropped
   endtask

   task automatic start_run(input int e, input bit push);
      bus.start_i = 1'b1;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      if (push) sb_q.push_back('{e: e, acc: cyc});
      @(negedge clk);
   endtask

   task automatic wait_seen(input int target);
      for (int k = 0; k < 400; k++) begin
         if (n_seen >= target) break;
         @(negedge clk);
      end
      if (n_seen < target) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: results seen %0d, expected %0d", n_seen, target);
      end
   endtask

   // Monitor: on each done_o pulse pop the expected item, then read every result word.
   initial begin
      item_t       it;
      logic [31:0] got;
      bus.rd_addr_i = '0;
      forever begin
         @(negedge clk);
         if (bus.done_o) begin
            if (sb_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_done: got a done_o pulse, expected none (t=%0t)", $time);
            end else begin
               it = sb_q.pop_front();
               check("latency", 32'(cyc - it.acc), 32'(L));
               check("busy_cycles", 32'(busy_cnt), 32'(L - 1));
               busy_cnt = 0;
               got = '0;
               for (int k = 0; k <= S; k++) begin
                  bus.rd_addr_i = AW'(k);
                  @(negedge clk);
                  busy_cnt = bus.busy_o ? busy_cnt + 1 : 0;
                  if (k == 0) check("done_one_cycle", 32'(bus.done_o), 32'd0);
                  if (k < S) got = got | (32'(bus.rd_data_o) << (k * W));
                  else       check("rd_out_of_range", 32'(bus.rd_data_o), 32'd0);
               end
               bus.rd_addr_i = '0;
`ifdef FIOS_MM_FINAL_SUB_EN
               check("result", got, 32'(it.e));
`else
               check("result_mod_p", got % P, 32'(it.e));
               check("result_lt_2p", 32'(got < 2 * P), 32'd1);
`endif
               n_seen++;
            end
         end else begin
            busy_cnt = bus.busy_o ? busy_cnt + 1 : 0;
         end
      end
   end

   initial begin
      int seen = 0;
`ifdef FIOS_MM_FINAL_SUB_EN
      vecs[0] = '{a: 'h01, b: 'h16, e: 'h4D};
      vecs[1] = '{a: 'h4D, b: 'h4D, e: 'h4D};
      vecs[2] = '{a: 'h02, b: 'h03, e: 'h15};
      vecs[3] = '{a: 'hB2, b: 'hB2, e: 'h5D};
      vecs[4] = '{a: 'h80, b: 'h9C, e: 'h4E};
`else
      vecs[0] = '{a: 'h01, b: 'h2A, e: 'h0D};
      vecs[1] = '{a: 'h01, b: 'h1C, e: 'h2C};
      vecs[2] = '{a: 'h2C, b: 'h2C, e: 'h2C};
      vecs[3] = '{a: 'h02, b: 'h03, e: 'h11};
      vecs[4] = '{a: 'h30, b: 'h31, e: 'h27};
`endif
      bus.start_i     = 1'b0;
      bus.wr_en_i     = 1'b0;
      bus.wr_sel_i    = '0;
      bus.wr_addr_i   = '0;
      bus.wr_data_i   = '0;
      bus.p_prime_0_i = W'(PP);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus.busy_o), 32'd0);
      check("rst_done", 32'(bus.done_o), 32'd0);
      check("rst_rd_data", 32'(bus.rd_data_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[v]) begin
         load(vecs[v].a, vecs[v].b);
         start_run(vecs[v].e, 1'b1);
         seen++;
         wait_seen(seen);
      end

      // start_i held high: one done per accepted start, second run re-accepted from IDLE
      load(0, R2);
      bus.start_i = 1'b1;
      @(posedge clk);
      #1;
      sb_q.push_back('{e: 0, acc: cyc});
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.done_o) break;
      end
      @(posedge clk);
      #1;
      sb_q.push_back('{e: 0, acc: cyc});
      @(negedge clk);
      bus.start_i = 1'b0;
      seen += 2;
      wait_seen(seen);
      repeat (2 * L) @(negedge clk);

      // write and start in the middle of a run are both ignored
      load(RM, RM);
      start_run(RM, 1'b1);
      repeat (4) @(negedge clk);
      bus.wr_en_i   = 1'b1;
      bus.wr_sel_i  = 2'd0;
      bus.wr_addr_i = '0;
      bus.wr_data_i = 4'hF;
      bus.start_i   = 1'b1;
      @(negedge clk);
      bus.wr_en_i   = 1'b0;
      bus.start_i   = 1'b0;
      seen++;
      wait_seen(seen);

      // asynchronous reset mid-run, then restart on the retained operands
      start_run(0, 1'b0);
      repeat (5) @(posedge clk);
      #2;
      check("busy_before_rst", 32'(bus.busy_o), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(bus.busy_o), 32'd0);
      check("abort_done", 32'(bus.done_o), 32'd0);
      check("abort_rd_data", 32'(bus.rd_data_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      start_run(RM, 1'b1);
      seen++;
      wait_seen(seen);
      repeat (2 * L) @(negedge clk);

      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
